span_renderer: RTL and testbench

- Parametrised scanline span renderer for the demo display path; successor to the fixed-ROM line renderer.
- Walks a run-time-writable row table (Y breakpoints) and edge table (X toggle points) each frame.
- Animates every coordinate as base + signed fixed-point offset × frame count, and emits a registered pixel colour.
- Sits after the VGA timing generator, which supplies x_pos/y_pos/row_phase/frame_start/blank; owns the frame counter.

---
 rtl/span_renderer.sv | 144 ++++++++++++++
 tb/tb_span_renderer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/span_renderer.sv
// rtl/span_renderer.sv - scanline span renderer with animated row/edge tables
// Walks a Y-breakpoint row table and X-toggle edge table, emitting a registered colour.
module span_renderer #(
  parameter int COORD_W  = 10,
  parameter int IDX_W    = 7,
  parameter int SPANS    = 4,
  parameter int OFS_W    = 8,
  parameter int OFS_FRAC = 5,
  parameter int FRAME_W  = 10,
  parameter int COLOUR_W = 6,
  localparam int EW      = $clog2(SPANS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           frame_start,
  input  logic                           row_phase,
  input  logic                           blank,
  input  logic [COORD_W-1:0]             x_pos,
  input  logic [COORD_W-1:0]             y_pos,
  input  logic [IDX_W-1:0]               start_idx,
  input  logic                           frame_run,
  input  logic                           frame_clr,
  input  logic                           row_colour_en,
  input  logic [COLOUR_W-1:0]            inside_colour,
  input  logic [COLOUR_W-1:0]            outside_colour,
  input  logic                           wr_en,
  input  logic                           wr_sel,
  input  logic [IDX_W+EW-1:0]            wr_addr,
  input  logic [COORD_W+OFS_W+COLOUR_W-1:0] wr_data,
  output logic [COLOUR_W-1:0]            colour,
  output logic [FRAME_W-1:0]             frame,
  output logic                           in_span,
  output logic [IDX_W-1:0]               row_idx
);

  localparam int DEPTH  = 1 << IDX_W;
  localparam int EDEPTH = DEPTH * SPANS;
  localparam int EB_W   = COORD_W + OFS_W;
  localparam int RB_W   = EB_W + COLOUR_W;
  localparam int PW     = OFS_W + FRAME_W + 1;

  localparam logic [RB_W-1:0]    ROW_INIT  = {{(COLOUR_W + OFS_W){1'b0}}, {COORD_W{1'b1}}};
  localparam logic [EB_W-1:0]    EDGE_INIT = {{OFS_W{1'b0}}, {COORD_W{1'b1}}};
  localparam logic [FRAME_W-1:0] FRAME_ONE = 1;
  localparam logic [IDX_W-1:0]   IDX_ONE   = 1;
  localparam logic [EW:0]        EDGE_ONE  = 1;

  logic [RB_W-1:0]     row_tab_q  [DEPTH];
  logic [EB_W-1:0]     edge_tab_q [EDEPTH];

  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic [IDX_W-1:0]    row_idx_q, row_idx_d;
  logic [EW:0]         edge_idx_q, edge_idx_d;
  logic                in_span_q, in_span_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;

  logic [RB_W-1:0]     row_ent;
  logic [EB_W-1:0]     edge_ent;
  logic [EB_W-1:0]     sel_ent;
  logic [COORD_W-1:0]  sel_pos;
  logic [OFS_W-1:0]    sel_ofs;
  logic [PW-1:0]       ofs_x, frame_x, prod;
  logic [COORD_W:0]    eff;
  logic                match;
  logic                unused_prod_bits;

  assign row_ent  = row_tab_q[row_idx_q];
  assign edge_ent = edge_tab_q[{row_idx_q, edge_idx_q[EW-1:0]}];
  assign sel_ent  = row_phase ? row_ent[EB_W-1:0] : edge_ent;
  assign sel_pos  = row_phase ? y_pos : x_pos;
  assign sel_ofs  = sel_ent[EB_W-1:COORD_W];

  // Operands extended to the full product width, so the low bits equal the signed product.
  assign ofs_x   = {{(PW - OFS_W){sel_ofs[OFS_W-1]}}, sel_ofs};
  assign frame_x = {{(PW - FRAME_W){1'b0}}, frame_q};
  assign prod    = ofs_x * frame_x;

  // Taking bits above OFS_FRAC is the flooring arithmetic shift, reduced mod 2^(COORD_W+1).
  assign eff   = {1'b0, sel_ent[COORD_W-1:0]} + prod[OFS_FRAC +: COORD_W+1];
  assign match = (eff == {1'b0, sel_pos});
  assign unused_prod_bits = ^{prod[PW-1:OFS_FRAC+COORD_W+1], prod[OFS_FRAC-1:0]};

  always_comb begin
    frame_d    = frame_q;
    row_idx_d  = row_idx_q;
    edge_idx_d = edge_idx_q;
    in_span_d  = in_span_q;
    colour_d   = outside_colour;

    if (frame_start) begin
      if (frame_clr)      frame_d = '0;
      else if (frame_run) frame_d = frame_q + FRAME_ONE;
    end

    if (frame_start) begin
      row_idx_d  = start_idx;
      edge_idx_d = '0;
      in_span_d  = 1'b0;
    end else if (row_phase) begin
      edge_idx_d = '0;
      in_span_d  = 1'b0;
      if (match) row_idx_d = row_idx_q + IDX_ONE;
    end else if (!edge_idx_q[EW] && match) begin
      // MSB of edge_idx set means all SPANS edges consumed for this line.
      edge_idx_d = edge_idx_q + EDGE_ONE;
      in_span_d  = !in_span_q;
    end

    if (blank)          colour_d = '0;
    else if (in_span_q) colour_d = row_colour_en ? row_ent[RB_W-1:EB_W] : inside_colour;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q    <= '0;
      row_idx_q  <= '0;
      edge_idx_q <= '0;
      in_span_q  <= 1'b0;
      colour_q   <= '0;
    end else begin
      frame_q    <= frame_d;
      row_idx_q  <= row_idx_d;
      edge_idx_q <= edge_idx_d;
      in_span_q  <= in_span_d;
      colour_q   <= colour_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)  row_tab_q[i]  <= ROW_INIT;
      for (int i = 0; i < EDEPTH; i++) edge_tab_q[i] <= EDGE_INIT;
    end else if (wr_en) begin
      if (wr_sel) edge_tab_q[wr_addr]             <= wr_data[EB_W-1:0];
      else        row_tab_q[wr_addr[IDX_W-1:0]]   <= wr_data;
    end
  end

  assign colour  = colour_q;
  assign frame   = frame_q;
  assign in_span = in_span_q;
  assign row_idx = row_idx_q;

endmodule

// File: tb/tb_span_renderer.sv
// tb/tb_span_renderer.sv - directed bench for span_renderer
module tb_span_renderer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        row_phase = 1'b1;
  logic        blank = 1'b1;
  logic [9:0]  x_pos = 10'd1000;
  logic [9:0]  y_pos = 10'd1000;
  logic [6:0]  start_idx = 7'd0;
  logic        frame_run = 1'b0;
  logic        frame_clr = 1'b0;
  logic        row_colour_en = 1'b0;
  logic [5:0]  inside_colour = 6'h15;
  logic [5:0]  outside_colour = 6'h2a;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [8:0]  wr_addr = 9'd0;
  logic [23:0] wr_data = 24'd0;
  logic [5:0]  colour;
  logic [9:0]  frame;
  logic        in_span;
  logic [6:0]  row_idx;

  localparam logic [5:0] IN_C  = 6'h15;
  localparam logic [5:0] OUT_C = 6'h2a;
  localparam logic [5:0] ROW_C = 6'h3c;

  int n_tests = 0;
  int n_fail  = 0;

  logic       span_at  [0:1023];
  logic [5:0] col_at   [0:1023];
  logic       exp_span [0:1023];
  logic [5:0] exp_col  [0:1023];

  span_renderer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .row_phase(row_phase), .blank(blank),
    .x_pos(x_pos), .y_pos(y_pos), .start_idx(start_idx), .frame_run(frame_run),
    .frame_clr(frame_clr), .row_colour_en(row_colour_en), .inside_colour(inside_colour),
    .outside_colour(outside_colour), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .colour(colour), .frame(frame), .in_span(in_span), .row_idx(row_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] mk(input logic [5:0] c, input logic [7:0] o, input logic [9:0] b);
    return {c, o, b};
  endfunction

  // Reference line: in_span during cycle x is the parity of toggle points strictly below x;
  // colour during cycle x reflects the previous cycle (row phase before x=0 is blanked).
  function automatic void build_exp(input int t0, input int t1, input int t2, input int t3,
                                    input logic [5:0] ins, input bit blk);
    int cnt;
    for (int x = 0; x <= 1023; x++) begin
      cnt = 0;
      if (t0 >= 0 && t0 < x) cnt++;
      if (t1 >= 0 && t1 < x) cnt++;
      if (t2 >= 0 && t2 < x) cnt++;
      if (t3 >= 0 && t3 < x) cnt++;
      exp_span[x] = cnt[0];
      if (x == 0 || blk) exp_col[x] = 6'h00;
      else               exp_col[x] = exp_span[x-1] ? ins : OUT_C;
    end
  endfunction

  task automatic write_tab(input logic sel, input logic [8:0] addr, input logic [23:0] data);
    @(posedge clk); #1;
    row_phase = 1'b1; blank = 1'b1; y_pos = 10'd1000;
    wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic fs_n(input int n, input logic run, input logic clr);
    @(posedge clk); #1;
    row_phase = 1'b1; blank = 1'b1; y_pos = 10'd1000; wr_en = 1'b0;
    frame_start = 1'b1; frame_run = run; frame_clr = clr;
    repeat (n) @(posedge clk);
    #1;
    frame_start = 1'b0; frame_run = 1'b0; frame_clr = 1'b0;
  endtask

  task automatic run_line(input int y, input int xmax, input int wr_x, input bit blk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      row_phase = 1'b1; blank = 1'b1; y_pos = 10'(y); x_pos = 10'd1000; wr_en = 1'b0;
    end
    for (int x = 0; x <= xmax; x++) begin
      @(posedge clk); #1;
      row_phase = 1'b0; blank = blk; x_pos = 10'(x); wr_en = (x == wr_x);
      @(negedge clk);
      span_at[x] = in_span;
      col_at[x]  = colour;
    end
  endtask

  task automatic test_reset;
    int bad, bx;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (colour !== 6'h00) begin n_fail++; $display("FAIL reset_colour: got %h want 00", colour); end
    n_tests++; if (frame !== 10'd0) begin n_fail++; $display("FAIL reset_frame: got %0d want 0", frame); end
    n_tests++; if (row_idx !== 7'd0) begin n_fail++; $display("FAIL reset_row_idx: got %0d want 0", row_idx); end
    n_tests++; if (in_span !== 1'b0) begin n_fail++; $display("FAIL reset_in_span: got %b want 0", in_span); end
    @(negedge clk); rst = 1'b0;
    fs_n(1, 1'b0, 1'b0);
    run_line(100, 300, -1, 1'b0);
    build_exp(-1, -1, -1, -1, IN_C, 1'b0);
    bad = 0; bx = 0;
    for (int x = 0; x <= 300; x++)
      if (span_at[x] !== exp_span[x] || col_at[x] !== exp_col[x]) begin
        if (bad == 0) bx = x;
        bad++;
      end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_no_edges: %0d bad, x=%0d span=%b want %b colour=%h want %h",
               bad, bx, span_at[bx], exp_span[bx], col_at[bx], exp_col[bx]);
    end
  endtask

  task automatic test_static;
    int ys [3] = '{99, 100, 101};
    int bad, bx;
    write_tab(1'b0, 9'd0, mk(6'h00, 8'h00, 10'd100));
    write_tab(1'b1, 9'd4, mk(6'h00, 8'h00, 10'd150));
    write_tab(1'b1, 9'd5, mk(6'h00, 8'h00, 10'd250));
    fs_n(1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      run_line(ys[k], 300, -1, 1'b0);
      if (ys[k] < 100) build_exp(-1, -1, -1, -1, IN_C, 1'b0);
      else             build_exp(150, 250, -1, -1, IN_C, 1'b0);
      bad = 0; bx = 0;
      for (int x = 0; x <= 300; x++)
        if (span_at[x] !== exp_span[x] || col_at[x] !== exp_col[x]) begin
          if (bad == 0) bx = x;
          bad++;
        end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL static_y%0d: %0d bad, x=%0d span=%b want %b colour=%h want %h",
                 ys[k], bad, bx, span_at[bx], exp_span[bx], col_at[bx], exp_col[bx]);
      end
      n_tests++;
      if (row_idx !== ((ys[k] < 100) ? 7'd0 : 7'd1)) begin
        n_fail++;
        $display("FAIL static_row_idx_y%0d: got %0d want %0d", ys[k], row_idx, (ys[k] < 100) ? 0 : 1);
      end
    end
  endtask

  task automatic test_start_idx;
    start_idx = 7'd5;
    fs_n(1, 1'b0, 1'b0);
    n_tests++; if (row_idx !== 7'd5) begin n_fail++; $display("FAIL start_idx_5: got %0d want 5", row_idx); end
    start_idx = 7'd0;
    fs_n(1, 1'b0, 1'b0);
    n_tests++; if (row_idx !== 7'd0) begin n_fail++; $display("FAIL start_idx_0: got %0d want 0", row_idx); end
  endtask

  task automatic test_animation;
    int bad, bx;
    for (int k = 0; k < 2; k++) begin
      write_tab(1'b1, 9'd4, mk(6'h00, (k == 0) ? 8'h20 : 8'hF0, 10'd150));
      fs_n(1, 1'b0, 1'b1);
      fs_n((k == 0) ? 10 : 9, 1'b1, 1'b0);
      n_tests++;
      if (frame !== ((k == 0) ? 10'd10 : 10'd9)) begin
        n_fail++; $display("FAIL anim_frame_%0d: got %0d want %0d", k, frame, (k == 0) ? 10 : 9);
      end
      run_line(100, 300, -1, 1'b0);
      build_exp((k == 0) ? 160 : 145, 250, -1, -1, IN_C, 1'b0);
      bad = 0; bx = 0;
      for (int x = 0; x <= 300; x++)
        if (span_at[x] !== exp_span[x] || col_at[x] !== exp_col[x]) begin
          if (bad == 0) bx = x;
          bad++;
        end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL anim_line_%0d: %0d bad, x=%0d span=%b want %b colour=%h want %h",
                 k, bad, bx, span_at[bx], exp_span[bx], col_at[bx], exp_col[bx]);
      end
    end
  endtask

  task automatic test_frame_ctrl;
    fs_n(1, 1'b0, 1'b1);
    fs_n(3, 1'b1, 1'b0);
    n_tests++; if (frame !== 10'd3) begin n_fail++; $display("FAIL frame_run3: got %0d want 3", frame); end
    fs_n(1, 1'b1, 1'b1);
    n_tests++; if (frame !== 10'd0) begin n_fail++; $display("FAIL frame_clr_wins: got %0d want 0", frame); end
    fs_n(2, 1'b1, 1'b0);
    fs_n(1, 1'b0, 1'b0);
    n_tests++; if (frame !== 10'd2) begin n_fail++; $display("FAIL frame_hold: got %0d want 2", frame); end
    fs_n(1, 1'b0, 1'b1);
    fs_n(1023, 1'b1, 1'b0);
    n_tests++; if (frame !== 10'd1023) begin n_fail++; $display("FAIL frame_max: got %0d want 1023", frame); end
    fs_n(1, 1'b1, 1'b0);
    n_tests++; if (frame !== 10'd0) begin n_fail++; $display("FAIL frame_wrap: got %0d want 0", frame); end
  endtask

  task automatic test_saturation;
    int bad, bx;
    write_tab(1'b1, 9'd4, mk(6'h00, 8'h00, 10'd10));
    write_tab(1'b1, 9'd5, mk(6'h00, 8'h00, 10'd20));
    write_tab(1'b1, 9'd6, mk(6'h00, 8'h00, 10'd30));
    write_tab(1'b1, 9'd7, mk(6'h00, 8'h00, 10'd40));
    write_tab(1'b0, 9'd1, mk(ROW_C, 8'h00, 10'h3FF));
    row_colour_en = 1'b1;
    fs_n(1, 1'b0, 1'b1);
    run_line(100, 300, -1, 1'b0);
    build_exp(10, 20, 30, 40, ROW_C, 1'b0);
    bad = 0; bx = 0;
    for (int x = 0; x <= 300; x++)
      if (span_at[x] !== exp_span[x] || col_at[x] !== exp_col[x]) begin
        if (bad == 0) bx = x;
        bad++;
      end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL saturation_row_colour: %0d bad, x=%0d span=%b want %b colour=%h want %h",
               bad, bx, span_at[bx], exp_span[bx], col_at[bx], exp_col[bx]);
    end
    row_colour_en = 1'b0;
  endtask

  task automatic test_collision_blank;
    int ys [3] = '{100, 101, 101};
    int bad, bx;
    write_tab(1'b1, 9'd4, mk(6'h00, 8'h00, 10'd150));
    write_tab(1'b1, 9'd5, mk(6'h00, 8'h00, 10'd250));
    write_tab(1'b1, 9'd6, mk(6'h00, 8'h00, 10'h3FF));
    write_tab(1'b1, 9'd7, mk(6'h00, 8'h00, 10'h3FF));
    fs_n(1, 1'b0, 1'b0);
    wr_sel = 1'b1; wr_addr = 9'd4; wr_data = mk(6'h00, 8'h00, 10'd200);
    for (int k = 0; k < 3; k++) begin
      run_line(ys[k], 300, (k == 0) ? 150 : -1, (k == 2));
      build_exp((k == 0) ? 150 : 200, 250, -1, -1, IN_C, (k == 2));
      bad = 0; bx = 0;
      for (int x = 0; x <= 300; x++)
        if (span_at[x] !== exp_span[x] || col_at[x] !== exp_col[x]) begin
          if (bad == 0) bx = x;
          bad++;
        end
      n_tests++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL collision_blank_%0d: %0d bad, x=%0d span=%b want %b colour=%h want %h",
                 k, bad, bx, span_at[bx], exp_span[bx], col_at[bx], exp_col[bx]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int bad, bx;
    write_tab(1'b1, 9'd4, mk(6'h00, 8'h00, 10'd150));
    fs_n(1, 1'b0, 1'b1);
    fs_n(5, 1'b1, 1'b0);
    run_line(100, 200, -1, 1'b0);
    n_tests++; if (in_span !== 1'b1) begin n_fail++; $display("FAIL pre_reset_in_span: got %b want 1", in_span); end
    n_tests++; if (frame !== 10'd5) begin n_fail++; $display("FAIL pre_reset_frame: got %0d want 5", frame); end
    n_tests++; if (colour !== IN_C) begin n_fail++; $display("FAIL pre_reset_colour: got %h want %h", colour, IN_C); end
    #2; rst = 1'b1; #1;
    n_tests++; if (colour !== 6'h00) begin n_fail++; $display("FAIL async_colour: got %h want 00", colour); end
    n_tests++; if (frame !== 10'd0) begin n_fail++; $display("FAIL async_frame: got %0d want 0", frame); end
    n_tests++; if (row_idx !== 7'd0) begin n_fail++; $display("FAIL async_row_idx: got %0d want 0", row_idx); end
    n_tests++; if (in_span !== 1'b0) begin n_fail++; $display("FAIL async_in_span: got %b want 0", in_span); end
    @(negedge clk); rst = 1'b0;
    fs_n(1, 1'b0, 1'b0);
    run_line(100, 300, -1, 1'b0);
    build_exp(-1, -1, -1, -1, IN_C, 1'b0);
    bad = 0; bx = 0;
    for (int x = 0; x <= 300; x++)
      if (span_at[x] !== exp_span[x] || col_at[x] !== exp_col[x]) begin
        if (bad == 0) bx = x;
        bad++;
      end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL post_reset_tables: %0d bad, x=%0d span=%b want %b colour=%h want %h",
               bad, bx, span_at[bx], exp_span[bx], col_at[bx], exp_col[bx]);
    end
    n_tests++; if (row_idx !== 7'd0) begin n_fail++; $display("FAIL post_reset_row_idx: got %0d want 0", row_idx); end
  endtask

  initial begin
    test_reset();
    test_static();
    test_start_idx();
    test_animation();
    test_frame_ctrl();
    test_saturation();
    test_collision_blank();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
